// File: rtl/debounce_sync_if.sv
// Signal bundle for the debounce/synchronizer block.
// The master drives the raw level, and the slave returns the conditioned outputs.
interface debounce_sync_if #(
  parameter int GLITCH_W = 8
);
  logic                din;
  logic                q;
  logic                qn;
  logic                rise;
  logic                fall;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (output din, input q, qn, rise, fall, glitch_cnt);
  modport slave  (input din, output q, qn, rise, fall, glitch_cnt);
endinterface

// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous level and debounces it over a stability window.
// Outputs a registered level and its complement, edge strobes, and a saturating count of aborted transitions.
module debounce_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 8,
  parameter int GLITCH_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  debounce_sync_if.slave  bus
);
  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_sync;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   q_r, q_d, qn_r;
  logic                   rise_r, rise_d, fall_r, fall_d;
  logic [GLITCH_W-1:0]    glitch_r, glitch_d;

  assign s_sync = sync[SYNC_STAGES-1];

  // NOTE: every output of this block gets a default first, so no path can leave a value unassigned and infer a latch.
  always_comb begin
    cnt_d    = cnt;
    q_d      = q_r;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_r;
    if (s_sync != q_r) begin
      if (cnt == CNT_LAST) begin
        q_d    = s_sync;
        cnt_d  = '0;
        rise_d = s_sync;
        fall_d = ~s_sync;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end else if (cnt != '0) begin
      // Input returned to q before the window expired: count an aborted transition.
      cnt_d = '0;
      if (glitch_r != '1) glitch_d = glitch_r + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      cnt      <= '0;
      q_r      <= 1'b0;
      qn_r     <= 1'b1;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      glitch_r <= '0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], bus.din};
      cnt      <= cnt_d;
      q_r      <= q_d;
      qn_r     <= ~q_d;
      rise_r   <= rise_d;
      fall_r   <= fall_d;
      glitch_r <= glitch_d;
    end
  end

  assign bus.q          = q_r;
  assign bus.qn         = qn_r;
  assign bus.rise       = rise_r;
  assign bus.fall       = fall_r;
  assign bus.glitch_cnt = glitch_r;
endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync using two instances with SYNC_STAGES=2 and STABLE_CNT=4.
// Instance a has an 8-bit glitch counter; instance b has a 2-bit counter to exercise saturation.
module tb_debounce_sync;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debounce_sync_if #(.GLITCH_W(8)) bus_a ();
  debounce_sync_if #(.GLITCH_W(2)) bus_b ();

  debounce_sync #(.SYNC_STAGES(2), .STABLE_CNT(4), .GLITCH_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  debounce_sync #(.SYNC_STAGES(2), .STABLE_CNT(4), .GLITCH_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave));

  int n_cmp = 0;
  int n_err = 0;
  int rises_a = 0, falls_a = 0, rises_b = 0;
  int n;
  int bad;

  // Strobes last one cycle, so each pulse is seen at exactly one falling edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      rises_a += int'(bus_a.rise);
      falls_a += int'(bus_a.fall);
      rises_b += int'(bus_b.rise);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic set_din(input logic v);
    @(negedge clk);
    bus_a.din = v;
    bus_b.din = v;
  endtask

  task automatic clear_mon();
    rises_a = 0;
    falls_a = 0;
    rises_b = 0;
  endtask

  // Counts rising edges until q on instance a reaches target, with a bound.
  task automatic measure(input logic target, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (bus_a.q !== target && edges < 30);
  endtask

  task automatic glitch_pulse();
    set_din(1'b1);
    @(negedge clk);
    set_din(1'b0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus_a.din = 1'b0;
    bus_b.din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", 32'(bus_a.q), 0);
    check("rst_qn", 32'(bus_a.qn), 1);
    check("rst_rise", 32'(bus_a.rise), 0);
    check("rst_fall", 32'(bus_a.fall), 0);
    check("rst_glitch", 32'(bus_a.glitch_cnt), 0);

    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.q !== 1'b0 || bus_a.qn !== 1'b1 || bus_a.rise !== 1'b0 ||
          bus_a.fall !== 1'b0 || bus_a.glitch_cnt !== 8'd0) bad++;
    end
    check("idle_hold_20", 32'(bad), 0);

    // Clean 0 to 1 step. q changes at edge 5, which is the sixth edge sampled.
    clear_mon();
    set_din(1'b1);
    measure(1'b1, n);
    check("rise_latency", 32'(n), 6);
    check("rise_q", 32'(bus_a.q), 1);
    check("rise_qn", 32'(bus_a.qn), 0);
    check("rise_pulse", 32'(bus_a.rise), 1);
    check("rise_no_fall", 32'(bus_a.fall), 0);
    check("rise_q_b", 32'(bus_b.q), 1);
    @(posedge clk);
    #1;
    check("rise_pulse_end", 32'(bus_a.rise), 0);
    repeat (4) @(posedge clk);
    check("rise_count", 32'(rises_a), 1);
    check("rise_fall_count", 32'(falls_a), 0);
    check("rise_glitch", 32'(bus_a.glitch_cnt), 0);

    // Clean 1 to 0 step.
    clear_mon();
    set_din(1'b0);
    measure(1'b0, n);
    check("fall_latency", 32'(n), 6);
    check("fall_qn", 32'(bus_a.qn), 1);
    check("fall_pulse", 32'(bus_a.fall), 1);
    check("fall_no_rise", 32'(bus_a.rise), 0);
    @(posedge clk);
    #1;
    check("fall_pulse_end", 32'(bus_a.fall), 0);
    repeat (4) @(posedge clk);
    check("fall_count", 32'(falls_a), 1);
    check("fall_rise_count", 32'(rises_a), 0);

    // Three 2-cycle pulses, each separated by 6 low cycles, are all rejected.
    clear_mon();
    for (int i = 0; i < 3; i++) glitch_pulse();
    repeat (4) @(posedge clk);
    #1;
    check("glitch_q", 32'(bus_a.q), 0);
    check("glitch_rises", 32'(rises_a), 0);
    check("glitch_cnt_a3", 32'(bus_a.glitch_cnt), 3);
    check("glitch_cnt_b3", 32'(bus_b.glitch_cnt), 3);

    // Two more pulses: the 2-bit counter saturates at 3 instead of wrapping.
    for (int i = 0; i < 2; i++) glitch_pulse();
    repeat (4) @(posedge clk);
    #1;
    check("glitch_cnt_a5", 32'(bus_a.glitch_cnt), 5);
    check("glitch_sat_b", 32'(bus_b.glitch_cnt), 3);
    check("glitch_rises_b", 32'(rises_b), 0);

    // Reset two counts into a valid rise, then release with din still high.
    clear_mon();
    set_din(1'b1);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_q", 32'(bus_a.q), 0);
    check("midrst_qn", 32'(bus_a.qn), 1);
    check("midrst_rise", 32'(bus_a.rise), 0);
    check("midrst_glitch_a", 32'(bus_a.glitch_cnt), 0);
    check("midrst_glitch_b", 32'(bus_b.glitch_cnt), 0);
    check("midrst_no_rise", 32'(rises_a), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    measure(1'b1, n);
    check("postrst_latency", 32'(n), 6);
    check("postrst_pulse", 32'(bus_a.rise), 1);
    repeat (4) @(posedge clk);
    check("postrst_rise_count", 32'(rises_a), 1);
    check("postrst_glitch", 32'(bus_a.glitch_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Input-conditioning stage that sits directly upstream of the team's D flip-flop and register blocks.
- Takes a raw asynchronous, possibly bouncy level (switch, external pin) and passes it through a multi-stage synchronizer.
- Filters out pulses shorter than a programmable stability window.
- Delivers a clean registered level with its complement, plus single-cycle rise/fall strobes and a saturating glitch counter for diagnostics.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range >= 2.
- STABLE_CNT, 8, consecutive cycles the synchronized input must differ from q before q changes; legal range >= 1.
- GLITCH_W, 8, width of the saturating glitch counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  raw asynchronous input level.
- q  output  1  debounced, synchronized level.
- qn  output  1  always ~q.
- rise  output  1  one-cycle pulse, asserted in the cycle q goes 0->1.
- fall  output  1  one-cycle pulse, asserted in the cycle q goes 1->0.
- glitch_cnt  output  GLITCH_W  count of aborted transitions; saturating.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset (async, takes effect immediately, including mid-count):
  - synchronizer chain = 0, stability counter = 0.
  - q = 0, qn = 1, rise = 0, fall = 0, glitch_cnt = 0.
- Synchronizer:
  - din is shifted through SYNC_STAGES flops.
  - s_sync is the last stage, so it reflects din after SYNC_STAGES edges.
  - No logic is applied to din before the first flop.
- Stability counter: width = clog2(STABLE_CNT+1), derived internally. On each posedge:
  - s_sync != q and cnt < STABLE_CNT-1: cnt <= cnt+1.
  - s_sync != q and cnt == STABLE_CNT-1: q <= s_sync, cnt <= 0, and rise or fall <= 1 as appropriate (same edge as q changes).
  - s_sync == q and cnt != 0 (aborted transition): cnt <= 0, glitch_cnt <= glitch_cnt+1 unless already all-ones.
  - s_sync == q and cnt == 0: hold.
- rise and fall default to 0 every cycle; each is high for exactly one cycle per q change and never both high at once.
- Latency: a clean din step sampled at edge E changes q at edge E + SYNC_STAGES + STABLE_CNT - 1.
  - Defaults: 9 edges after the first sampling edge.
- STABLE_CNT = 1: q follows s_sync with one extra register stage; glitch_cnt never increments.
- Pulse rejection: any din pulse whose synchronized width is < STABLE_CNT cycles never reaches q.
- qn is a registered complement, updated on the same edge as q (no combinational inversion glitch).
- glitch_cnt saturates at 2^GLITCH_W-1 and is cleared only by rst.
- Reset deasserted while din = 1: treated as a normal 0->1 transition; q rises with a rise pulse after the full latency.
- Reset asserted mid-count: the pending transition is discarded and no rise or fall pulse is emitted.

Test Plan:
- Reset with din=0, then release → q=0, qn=1, rise=fall=0, glitch_cnt=0 immediately and held for 20 cycles.
- Setup SYNC_STAGES=2, STABLE_CNT=4. Stimulus: din 0→1 just before edge 0 and held → q=1, qn=0 at edge 5 with rise=1 for exactly that cycle; fall stays 0; glitch_cnt=0.
- Same setup from q=1. Stimulus: din 1→0 held → q=0 at edge 5 after the step; one-cycle fall pulse.
- Same setup. Stimulus: din pulses high for 2 cycles, three times, separated by 6 low cycles → q stays 0, no rise, glitch_cnt=3.
- GLITCH_W=2. Stimulus: 5 short glitches → glitch_cnt ends at 3 (saturated), with no wrap to 0.
- Stimulus: rst asserted asynchronously mid-count, 2 cycles into a valid 0→1 transition → q=0, cnt cleared, no rise. After release with din still 1 → q rises at the full latency counted from the release.
